// File: rtl/reg_query_responder.sv
// reg_query_responder
// Register-file side of the register-query protocol. Holds the value, busy flag
// and producer tag for every architectural register. Source lookups return a
// response one cycle later, and rename requests take ownership of a destination.
// Busy entries are retired by CDB writebacks and cleared in bulk by flush.
// Register 0 is hardwired to zero and is never busy.

module reg_query_responder #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int TAG_WIDTH = 6,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 query_valid,
  input  logic [AW-1:0]        src1_addr,
  input  logic [AW-1:0]        src2_addr,
  input  logic [AW-1:0]        dst_addr,
  input  logic                 rename,
  input  logic [TAG_WIDTH-1:0] dst_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [AW-1:0]        cdb_addr,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [XLEN-1:0]      src1_data,
  output logic [XLEN-1:0]      src2_data,
  output logic [TAG_WIDTH-1:0] src1_tag,
  output logic [TAG_WIDTH-1:0] src2_tag,
  output logic                 src1_ready,
  output logic                 src2_ready,
  output logic [1:0]           rename_status
);

  localparam logic [1:0] RS_NONE     = 2'b00;
  localparam logic [1:0] RS_RENAMED  = 2'b01;
  localparam logic [1:0] RS_REJECTED = 2'b10;

  // Architectural state
  logic [XLEN-1:0]      value_q [REG_COUNT];
  logic [XLEN-1:0]      value_d [REG_COUNT];
  logic [TAG_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [TAG_WIDTH-1:0] tag_d   [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // Registered response
  logic                 out_valid_q,     out_valid_d;
  logic [XLEN-1:0]      src1_data_q,     src1_data_d;
  logic [XLEN-1:0]      src2_data_q,     src2_data_d;
  logic [TAG_WIDTH-1:0] src1_tag_q,      src1_tag_d;
  logic [TAG_WIDTH-1:0] src2_tag_q,      src2_tag_d;
  logic                 src1_ready_q,    src1_ready_d;
  logic                 src2_ready_q,    src2_ready_d;
  logic [1:0]           rename_status_q, rename_status_d;

  // Per-source lookup results (index 0 = src1, 1 = src2)
  logic [AW-1:0]        lk_addr  [2];
  logic                 lk_ready [2];
  logic [XLEN-1:0]      lk_data  [2];
  logic [TAG_WIDTH-1:0] lk_tag   [2];

  logic resp_valid;
  logic rename_req;
  logic rename_ok;
  logic cdb_hit;

  assign resp_valid = query_valid & ~flush;
  assign rename_req = query_valid & rename;
  assign rename_ok  = rename_req & (dst_addr != '0) & ~flush;
  // A CDB result retires its register only if that register is still owned by
  // the broadcasting tag; stale tags and x0 fall out because x0 is never busy.
  assign cdb_hit    = cdb_valid & (cdb_addr != '0) & busy_q[cdb_addr] &
                      (tag_q[cdb_addr] == cdb_tag);

  // Source lookup against pre-rename state, with same-cycle CDB bypass
  always_comb begin
    lk_addr[0] = src1_addr;
    lk_addr[1] = src2_addr;
    for (int s = 0; s < 2; s++) begin
      lk_ready[s] = 1'b0;
      lk_data[s]  = '0;
      lk_tag[s]   = '0;
      if (!busy_q[lk_addr[s]]) begin
        lk_ready[s] = 1'b1;
        lk_data[s]  = value_q[lk_addr[s]];
      end else if (cdb_valid && (cdb_addr == lk_addr[s]) &&
                   (cdb_tag == tag_q[lk_addr[s]])) begin
        lk_ready[s] = 1'b1;
        lk_data[s]  = cdb_data;
      end else begin
        lk_tag[s]   = tag_q[lk_addr[s]];
      end
    end
  end

  // Next response; outputs are zeroed whenever no response is produced
  always_comb begin
    out_valid_d  = resp_valid;
    src1_ready_d = 1'b0;
    src1_data_d  = '0;
    src1_tag_d   = '0;
    src2_ready_d = 1'b0;
    src2_data_d  = '0;
    src2_tag_d   = '0;
    if (resp_valid) begin
      src1_ready_d = lk_ready[0];
      src1_data_d  = lk_data[0];
      src1_tag_d   = lk_tag[0];
      src2_ready_d = lk_ready[1];
      src2_data_d  = lk_data[1];
      src2_tag_d   = lk_tag[1];
    end
    if (!rename_req) begin
      rename_status_d = RS_NONE;
    end else if (rename_ok) begin
      rename_status_d = RS_RENAMED;
    end else begin
      rename_status_d = RS_REJECTED;
    end
  end

  // Next register-file state: CDB retire, then rename (wins on busy/tag), then flush
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (cdb_hit) begin
      value_d[cdb_addr] = cdb_data;
      busy_d[cdb_addr]  = 1'b0;
    end
    if (rename_ok) begin
      busy_d[dst_addr] = 1'b1;
      tag_d[dst_addr]  = dst_tag;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // Register-file state flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  // Response flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q     <= 1'b0;
      src1_ready_q    <= 1'b0;
      src1_data_q     <= '0;
      src1_tag_q      <= '0;
      src2_ready_q    <= 1'b0;
      src2_data_q     <= '0;
      src2_tag_q      <= '0;
      rename_status_q <= RS_NONE;
    end else begin
      out_valid_q     <= out_valid_d;
      src1_ready_q    <= src1_ready_d;
      src1_data_q     <= src1_data_d;
      src1_tag_q      <= src1_tag_d;
      src2_ready_q    <= src2_ready_d;
      src2_data_q     <= src2_data_d;
      src2_tag_q      <= src2_tag_d;
      rename_status_q <= rename_status_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign src1_ready    = src1_ready_q;
  assign src1_data     = src1_data_q;
  assign src1_tag      = src1_tag_q;
  assign src2_ready    = src2_ready_q;
  assign src2_data     = src2_data_q;
  assign src2_tag      = src2_tag_q;
  assign rename_status = rename_status_q;

endmodule

// File: doc/reg_query_responder.md
# reg_query_responder

Register-file end of the register-query protocol: accepts source/destination lookups and rename requests from the renamer, and returns operand values or the producer tag for each source one cycle later. Holds the architectural value, busy flag and producer tag for every register. Busy entries are retired by common-data-bus (CDB) writebacks and cleared in bulk by a pipeline flush. Sits between the renamer and the dispatch/resolver stage in the mk_II core.

## Interface
- XLEN, 32, data width of every register and CDB result
- REG_COUNT, 32, architectural registers; address width is $clog2(REG_COUNT)
- TAG_WIDTH, 6, width of producer (ROB) tags
- clk  in  1  core clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset; one clock domain, no other clock
- query_valid  in  1  a lookup is presented this cycle
- src1_addr, src2_addr  in  $clog2(REG_COUNT)  source register addresses
- dst_addr  in  $clog2(REG_COUNT)  destination register address
- rename  in  1  with query_valid: mark dst_addr busy, owned by dst_tag
- dst_tag  in  TAG_WIDTH  new producer tag for dst_addr
- cdb_valid  in  1  a result is broadcast this cycle
- cdb_tag  in  TAG_WIDTH  producer tag of the broadcast result
- cdb_addr  in  $clog2(REG_COUNT)  destination register of the broadcast result
- cdb_data  in  XLEN  broadcast result value
- flush  in  1  discard all speculative renames
- out_valid  out  1  registered; outputs below carry a response
- src1_data, src2_data  out  XLEN  operand value; meaningful only when srcN_ready
- src1_tag, src2_tag  out  TAG_WIDTH  producer tag; meaningful only when !srcN_ready
- src1_ready, src2_ready  out  1  1 = value present, 0 = wait for the tag
- rename_status  out  2  00 none, 01 renamed, 10 rejected (dst x0 or flush), 11 reserved/never driven

## Operation
- Per-register state: value[XLEN], busy, tag[TAG_WIDTH]. Register 0 is hardwired: value 0, never busy.
- Lookup for each source, evaluated in the query cycle and registered:
  - If the register is not busy: ready=1, data=value.
  - If it is busy and a CDB broadcast this cycle has a matching cdb_tag and cdb_addr: ready=1, data=cdb_data (bypass).
  - Otherwise: ready=0, tag=stored tag, data=0.
- Sources read the state from before this cycle's rename: src==dst with rename returns the old mapping.
- Rename (query_valid & rename & dst_addr!=0 & !flush): busy[dst]=1, tag[dst]=dst_tag; rename_status=01.
- Rename is rejected when dst_addr==0 or flush is high; rename_status=10.
- rename_status=00 when there is no rename request or query_valid is low.
- CDB writeback: if cdb_valid, busy[cdb_addr] is set and tag[cdb_addr]==cdb_tag, then value=cdb_data and busy=0.
- A stale tag (no match) is ignored and the value is not written. A broadcast to x0 is ignored.
- CDB and rename to the same register in the same cycle: the rename wins, so the register stays busy with dst_tag. The CDB value is still written to value.
- flush: all busy bits cleared next edge; values are kept; any query that cycle yields out_valid=0.
- The CDB write in a flush cycle is still applied.

## Timing
- Latency: 1 cycle. Response to a query in cycle N appears in cycle N+1 with out_valid=1.
- out_valid is low in cycle N+1 when query_valid was low or flush was high in cycle N.
- Full throughput: a new query is accepted every cycle; there is no backpressure.
- Reset (asynchronous assert, released synchronously to clk by the environment):
  - All values, busy bits and tags become 0.
  - out_valid=0, rename_status=00, all srcN_* outputs 0.
  - Reset mid-query drops the response; there is no partial state.
- Outputs are register outputs only; there is no combinational path from inputs to outputs.

## Test plan
- Reset then query src1=5, src2=0 -> next cycle out_valid=1, both ready=1, data=0.
- Rename dst=3, tag=0x12; next cycle query src1=3 -> src1_ready=0, src1_tag=0x12; rename_status was 01.
- CDB tag=0x12, addr=3, data=0xDEADBEEF in the same cycle as a query of src1=3 -> src1_ready=1, src1_data=0xDEADBEEF; the register is then not busy.
- Rename x3 tag 0x20, then CDB for x3 with old tag 0x12 -> value unchanged and still busy; query returns tag 0x20.
- Rename dst=0 -> rename_status=10 and x0 still reads 0 ready. Query src1=dst=7 with rename tag 0x05 -> src1 returns the prior state (ready=1).
- Rename x4 and x5, then assert flush together with a query -> out_valid=0 next cycle; a later query of x4/x5 returns ready=1 with the old values.
